i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
// - I2C target (slave) responder: the bus end addressed by our I2C master sequencer; register-pointer protocol.
// - Used for loopback self-test of the master path and as an on-chip configuration slave.
// - Samples oversampled SCL/SDA, ACKs its 7-bit address, takes a register pointer, then writes or reads bytes with auto-increment.
// - Drives SDA open-drain only (pull-low enable); never drives SCL (no clock stretching).
// PARAMETERS
// - DEV_ADDR     7'h39  7-bit target address matched after START.
// - AW           8      register pointer width; pointer wraps modulo 2**AW.
// - FILTER_LEN   3      consecutive equal samples required before SCL/SDA level change accepted (glitch filter).
// - DATA_HOLD    5      clk_i cycles after filtered SCL fall before sda_oe_o may change.
// PORTS
// - clk_i        in   1   system clock; all logic on rising edge.
// - rst_i        in   1   synchronous reset, active-high.
// - scl_i        in   1   raw SCL from pad (asynchronous).
// - sda_i        in   1   raw SDA from pad (asynchronous).
// - sda_oe_o     out  1   1 = pull SDA low; 0 = release (pad tristate).
// - reg_addr_o   out  AW  register address for current access.
// - reg_wdata_o  out  8   write data, valid with reg_we_o.
// - reg_we_o     out  1   1-cycle write strobe.
// - reg_re_o     out  1   1-cycle read strobe; reg_rdata_i sampled exactly 1 cycle later.
// - reg_rdata_i  in   8   read data from register bank.
// - busy_o       out  1   1 from address match until STOP/abort.
// BEHAVIOUR
// - Reset: sda_oe_o=0, reg_we_o=0, reg_re_o=0, busy_o=0, reg_addr_o=0, reg_wdata_o=0; state IDLE; filters preset to 1.
// - Input path: 2-FF synchronizer, then FILTER_LEN filter; edge detect on filtered levels only.
// - START: filtered SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both override any state, any cycle.
// - Bits sampled on SCL rise, MSB first; SDA driven changes DATA_HOLD cycles after SCL fall.
// - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RLOAD, RDATA, RACK, WAIT_STOP.
// - IDLE -START-> ADDR. ADDR: shift 8 bits; match {DEV_ADDR,R/W} -> ADDR_ACK, busy_o=1; mismatch -> WAIT_STOP, no ACK.
// - ADDR_ACK: pull SDA low for 9th clock (assert after 8th SCL fall+hold, release after 9th SCL fall+hold).
//   W -> PTR; R -> RLOAD.
// - PTR: 8 bits -> reg_addr_o <= byte[AW-1:0] (AW<8: upper bits ignored); PTR_ACK -> WDATA.
// - WDATA: 8 bits -> reg_we_o pulse 1 cycle after 8th SCL rise with reg_wdata_o; WDATA_ACK; pointer += 1 after ACK.
// - RLOAD: reg_re_o pulse at ACK-release; latch reg_rdata_i next cycle into shifter; -> RDATA (drive bit7 first).
//   sda_oe_o = ~bit; pointer += 1 after byte.
// - RACK: release SDA, sample master bit on 9th rise: 0 (ACK) -> RLOAD; 1 (NACK) -> WAIT_STOP.
// - WAIT_STOP: SDA released; only START/STOP leave. STOP -> IDLE, busy_o=0.
// - Repeated START: from any state -> ADDR, sda_oe_o released same cycle; pointer retained (write-ptr-then-read).
// - START/STOP mid-byte: partial byte discarded, no reg strobe issued.
// - reg_we_o and reg_re_o never high together; at most one strobe per byte.
// - Pointer wrap: 2**AW-1 + 1 -> 0, no error.
// - Reset mid-transfer: sda_oe_o=0 next clk_i edge; next activity requires fresh START.
// STRUCTURE
// - Package i2c_pkg: state enum i2c_tgt_st_t, I2C_RW_WRITE/I2C_RW_READ constants, ACK/NACK level constants.
//   Shared with master side.
// - Sub-module i2c_in_filter: synchronizer + FILTER_LEN filter + rise/fall detect; instantiated for SCL and SDA.
// - Top: bit counter (0..8), shift register, hold-delay counter, FSM, pointer register.
// TESTING
// - Write: START,0x72,0x10,0xA5,0x5A,STOP -> 4 ACKs; we at addr 0x10=A5, 0x11=5A; busy_o falls after STOP.
// - Read: START,0x72,0x20,Sr,0x73, master ACK,NACK, bank[0x20]=0x11,[0x21]=0x22 -> SDA 0x11,0x22; then released.
// - Mismatch: START,0x74,0x10,STOP -> no ACK (SDA high on 9th clock), no strobes, busy_o=0 throughout.
// - Wrap: AW=8, ptr 0xFF, data 0x01,0x02 -> writes 0xFF=01, 0x00=02.
// - Glitch: 2-cycle SDA low pulse while SCL high (FILTER_LEN=3) -> no START detected, state IDLE.
// - Abort: rst_i for 1 cycle mid-read while sda_oe_o=1 -> sda_oe_o=0 next cycle; following valid write ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM encoding, R/W and ACK bus levels.
package i2c_pkg;

    // Target FSM encoding, kept as plain constants for legacy tools
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RLOAD     = 4'd7;
    localparam logic [3:0] ST_RDATA     = 4'd8;
    localparam logic [3:0] ST_RACK      = 4'd9;
    localparam logic [3:0] ST_WAIT_STOP = 4'd10;

    // Enum view of the same encoding for the master side and debug
    typedef enum logic [3:0] {
        TGT_IDLE      = 4'd0,
        TGT_ADDR      = 4'd1,
        TGT_ADDR_ACK  = 4'd2,
        TGT_PTR       = 4'd3,
        TGT_PTR_ACK   = 4'd4,
        TGT_WDATA     = 4'd5,
        TGT_WDATA_ACK = 4'd6,
        TGT_RLOAD     = 4'd7,
        TGT_RDATA     = 4'd8,
        TGT_RACK      = 4'd9,
        TGT_WAIT_STOP = 4'd10
    } i2c_tgt_st_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Address byte as it appears on the wire: 7-bit address then R/W
    function automatic logic [7:0] i2c_addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioner: 2-FF synchronizer, run-length glitch filter, edge detect.
module i2c_in_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          accept_c;

    // New level accepted once it has differed for FILTER_LEN consecutive samples
    assign accept_c = (sync_q[1] != level_o) && (cnt_q == CW'(FILTER_LEN - 1));

    // Synchronizer, run counter and filtered level with edge pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_o <= 1'b1;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            rise_o <= accept_c & sync_q[1];
            fall_o <= accept_c & ~sync_q[1];
            if (sync_q[1] == level_o) begin
                cnt_q <= '0;
            end else if (accept_c) begin
                level_o <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target with register-pointer protocol and auto-increment; SDA open-drain only.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h39,
    parameter int unsigned AW         = 8,
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned DATA_HOLD  = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    output logic [AW-1:0] reg_addr_o,
    output logic [7:0]    reg_wdata_o,
    output logic          reg_we_o,
    output logic          reg_re_o,
    input  logic [7:0]    reg_rdata_i,
    output logic          busy_o
);

    localparam int unsigned HW   = $clog2(DATA_HOLD + 1);
    localparam logic [3:0]  BITS = 4'd8;

    logic          scl_lvl, scl_rise, scl_fall;
    logic          sda_lvl, sda_rise, sda_fall;
    logic          start_c, stop_c, hold_tick_c, match_c;
    logic [7:0]    rx_byte_c;
    logic [HW-1:0] hold_q;

    logic [3:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d;
    logic          re_dly_q;
    logic          sda_oe_d, we_d, re_d, busy_d;
    logic [AW-1:0] addr_d;
    logic [7:0]    wdata_d;

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raw_i   (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raw_i   (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // Bus conditions and the byte as it would look after shifting in the current SDA
    assign start_c   = sda_fall & scl_lvl;
    assign stop_c    = sda_rise & scl_lvl;
    assign rx_byte_c = {shift_q[6:0], sda_lvl};
    assign match_c   = (shift_q == i2c_addr_byte(DEV_ADDR, shift_q[0]));

    // Hold timer: ticks DATA_HOLD cycles after each filtered SCL fall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else if (scl_fall) begin
            hold_q <= HW'(DATA_HOLD);
        end else if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
        end
    end

    assign hold_tick_c = (hold_q == HW'(1));

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= I2C_RW_WRITE;
            re_dly_q    <= 1'b0;
            sda_oe_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            re_dly_q    <= reg_re_o;
            sda_oe_o    <= sda_oe_d;
            reg_addr_o  <= addr_d;
            reg_wdata_o <= wdata_d;
            reg_we_o    <= we_d;
            reg_re_o    <= re_d;
            busy_o      <= busy_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_o;
        addr_d    = reg_addr_o;
        wdata_d   = reg_wdata_o;
        we_d      = 1'b0;
        re_d      = 1'b0;
        busy_d    = busy_o;

        if (stop_c) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_c) begin
            // Also covers repeated START; the pointer is deliberately kept
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            // SDA only moves once the hold window after SCL fall has elapsed
            if (hold_tick_c) begin
                case (state_q)
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe_d = ~I2C_ACK;
                    ST_RDATA:                              sda_oe_d = ~shift_q[7];
                    default:                               sda_oe_d = 1'b0;
                endcase
            end

            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != BITS) begin
                        shift_d   = rx_byte_c;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == ST_WDATA && bit_cnt_q == 4'd7) begin
                            we_d    = 1'b1;
                            wdata_d = rx_byte_c;
                        end
                    end else if (scl_fall && bit_cnt_q == BITS) begin
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            if (match_c) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = shift_q[0];
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else if (state_q == ST_PTR) begin
                            addr_d  = AW'(shift_q);
                            state_d = ST_PTR_ACK;
                        end else begin
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        state_d = (rw_q == I2C_RW_READ) ? ST_RLOAD : ST_PTR;
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d = ST_WDATA;
                        addr_d  = reg_addr_o + AW'(1);
                    end
                end
                ST_RLOAD: begin
                    // Strobe at ACK release, capture read data the cycle after the strobe
                    if (hold_tick_c) begin
                        re_d = 1'b1;
                    end
                    if (re_dly_q) begin
                        shift_d   = reg_rdata_i;
                        sda_oe_d  = ~reg_rdata_i[7];
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BITS) begin
                            state_d = ST_RACK;
                            addr_d  = reg_addr_o + AW'(1);
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        shift_d = rx_byte_c;
                    end else if (scl_fall) begin
                        state_d = (shift_q[0] == I2C_NACK) ? ST_WAIT_STOP : ST_RLOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-level master model, register bank, write/read scoreboards.
module tb_i2c_target;

    localparam int Q = 20;

    logic       clk;
    logic       rst_i;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0]  bank [256];
    logic [15:0] wr_log [64];
    int          wr_n    = 0;
    int          re_n    = 0;
    int          both_n  = 0;
    int          busy_n  = 0;
    int          wr_rd   = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target #(
        .DEV_ADDR   (7'h39),
        .AW         (8),
        .FILTER_LEN (3),
        .DATA_HOLD  (5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_oe_o    (sda_oe),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank with one-cycle read latency, plus strobe logging
    always @(posedge clk) begin
        if (reg_re) begin
            reg_rdata <= bank[reg_addr];
            re_n      <= re_n + 1;
        end
        if (reg_we && wr_n < 64) begin
            wr_log[wr_n] <= {reg_addr, reg_wdata};
            wr_n         <= wr_n + 1;
        end
        if (reg_we && reg_re) both_n <= both_n + 1;
        if (busy) busy_n <= busy_n + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    task automatic clk_bit(input logic b, output logic smp);
        sda_m = b;    cyc(Q);
        scl_m = 1'b1; cyc(Q);
        smp = sda_bus; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, d);
            b[i] = d;
        end
        clk_bit(m_ack ? 1'b0 : 1'b1, d);
    endtask

    task automatic check_writes(input string tag);
        int          n_exp;
        logic [15:0] e;
        n_exp = exp_wr.size();
        chk({tag, "_wr_count"}, 16'(wr_n - wr_rd), 16'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            e = exp_wr.pop_front();
            if (wr_rd < wr_n) begin
                chk({tag, "_wr"}, wr_log[wr_rd], e);
                wr_rd++;
            end
        end
        wr_rd = wr_n;
    endtask

    task automatic write_txn(input string tag, input logic [7:0] ptr,
                             input logic [7:0] d0, input logic [7:0] d1);
        logic       a;
        logic [7:0] p;
        i2c_start();
        write_byte(8'h72, a); chk({tag, "_ack_addr"}, 16'(a), 16'h0);
        write_byte(ptr, a);   chk({tag, "_ack_ptr"}, 16'(a), 16'h0);
        p = ptr;
        exp_wr.push_back({p, d0});
        write_byte(d0, a);    chk({tag, "_ack_d0"}, 16'(a), 16'h0);
        p = p + 8'd1;
        exp_wr.push_back({p, d1});
        write_byte(d1, a);    chk({tag, "_ack_d1"}, 16'(a), 16'h0);
        chk({tag, "_busy_hi"}, 16'(busy), 16'h1);
        i2c_stop();
        cyc(10);
        chk({tag, "_busy_lo"}, 16'(busy), 16'h0);
        check_writes(tag);
    endtask

    initial begin
        logic       a;
        logic       got;
        logic [7:0] rb;
        int         we0, re0, busy0;

        for (int i = 0; i < 256; i++) bank[i] = 8'h00;
        bank[8'h20] = 8'h11;
        bank[8'h21] = 8'h22;
        bank[8'h30] = 8'h00;
        reg_rdata = 8'h00;
        rst_i = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        cyc(5);
        chk("rst_oe",    16'(sda_oe),    16'h0);
        chk("rst_busy",  16'(busy),      16'h0);
        chk("rst_we",    16'(reg_we),    16'h0);
        chk("rst_re",    16'(reg_re),    16'h0);
        chk("rst_addr",  16'(reg_addr),  16'h0);
        chk("rst_wdata", 16'(reg_wdata), 16'h0);
        rst_i = 1'b0;
        cyc(20);

        // Plain write with auto-increment
        write_txn("write", 8'h10, 8'hA5, 8'h5A);

        // Pointer write, repeated START, two reads (ACK then NACK)
        re0 = re_n;
        i2c_start();
        write_byte(8'h72, a); chk("read_ack_addw", 16'(a), 16'h0);
        write_byte(8'h20, a); chk("read_ack_ptr",  16'(a), 16'h0);
        i2c_start();
        write_byte(8'h73, a); chk("read_ack_addr", 16'(a), 16'h0);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        read_byte(1'b1, rb); chk("read_byte0", 16'(rb), 16'(exp_rd.pop_front()));
        read_byte(1'b0, rb); chk("read_byte1", 16'(rb), 16'(exp_rd.pop_front()));
        cyc(Q);
        chk("read_released", 16'(sda_oe), 16'h0);
        chk("read_re_count", 16'(re_n - re0), 16'h2);
        i2c_stop();
        cyc(10);
        chk("read_busy_lo", 16'(busy), 16'h0);
        check_writes("read");

        // Address mismatch: no ACK, no strobes, never busy
        we0 = wr_n; re0 = re_n; busy0 = busy_n;
        i2c_start();
        write_byte(8'h74, a); chk("mis_nack_addr", 16'(a), 16'h1);
        write_byte(8'h10, a); chk("mis_nack_ptr",  16'(a), 16'h1);
        i2c_stop();
        cyc(10);
        chk("mis_we",   16'(wr_n - we0),     16'h0);
        chk("mis_re",   16'(re_n - re0),     16'h0);
        chk("mis_busy", 16'(busy_n - busy0), 16'h0);
        wr_rd = wr_n;

        // Pointer wraps from 0xFF to 0x00
        write_txn("wrap", 8'hFF, 8'h01, 8'h02);

        // Short SDA glitch with SCL high must not look like a START
        cyc(20);
        sda_m = 1'b0; cyc(2);
        sda_m = 1'b1; cyc(20);
        scl_m = 1'b0; cyc(Q);
        write_byte(8'h72, a);
        chk("glitch_no_ack", 16'(a),    16'h1);
        chk("glitch_busy",   16'(busy), 16'h0);
        i2c_stop();
        cyc(10);

        // Reset while the target is pulling SDA low during a read
        i2c_start();
        write_byte(8'h72, a); chk("abort_ack_addw", 16'(a), 16'h0);
        write_byte(8'h30, a); chk("abort_ack_ptr",  16'(a), 16'h0);
        i2c_start();
        write_byte(8'h73, a); chk("abort_ack_addr", 16'(a), 16'h0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (sda_oe) got = 1'b1;
            else cyc(1);
        end
        chk("abort_oe_before", 16'(got), 16'h1);
        rst_i = 1'b1;
        cyc(1);
        chk("abort_oe_after", 16'(sda_oe), 16'h0);
        rst_i = 1'b0;
        sda_m = 1'b1;
        cyc(60);
        write_txn("after_abort", 8'h40, 8'h99, 8'h98);

        chk("we_re_overlap", 16'(both_n), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
